// File: rtl/dmem_access_unit_if.sv
// Bundle between the MEM-stage data-memory access unit, the pipeline and the data memory.
interface dmem_access_unit_if;
    logic [31:0] IN_address;
    logic [31:0] IN_store_data;
    logic        IN_mem_read;
    logic        IN_mem_write;
    logic [2:0]  IN_funct3;
    logic        busywait;
    logic [31:0] dmem_out;
    logic        access_fault;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_readdata;
    logic        mem_busywait;

    modport slave (
        input  IN_address, IN_store_data, IN_mem_read, IN_mem_write, IN_funct3,
        input  mem_readdata, mem_busywait,
        output busywait, dmem_out, access_fault,
        output mem_read, mem_write, mem_address, mem_writedata, mem_byteen
    );

    modport master (
        output IN_address, IN_store_data, IN_mem_read, IN_mem_write, IN_funct3,
        output mem_readdata, mem_busywait,
        input  busywait, dmem_out, access_fault,
        input  mem_read, mem_write, mem_address, mem_writedata, mem_byteen
    );
endinterface

// File: rtl/dmem_access_unit.sv
// Data-memory access unit: checks alignment/width legality, drives byte-lane memory
// strobes, formats load data and aborts accesses that stall for too long.
module dmem_access_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic             clk,
    input logic             reset,
    dmem_access_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state;
    logic [7:0]  wd_count;
    logic [2:0]  funct3_q;
    logic [1:0]  offset_q;
    logic        is_load_q;
    logic        request;
    logic        illegal;
    logic [31:0] lane;
    logic [31:0] load_value;
    logic [31:0] store_word;
    logic [3:0]  store_en;

    assign request      = bus.IN_mem_read | bus.IN_mem_write;
    assign bus.busywait = ((state == IDLE) & request) | (state == ACCESS);

    always_comb begin
        illegal = 1'b0;
        if (bus.IN_mem_read && bus.IN_mem_write)
            illegal = 1'b1;
        case (bus.IN_funct3)
            3'b011, 3'b110, 3'b111: illegal = 1'b1;
            3'b010:                 if (bus.IN_address[1:0] != 2'b00) illegal = 1'b1;
            3'b001, 3'b101:         if (bus.IN_address[0]) illegal = 1'b1;
            default: ;
        endcase
        if (bus.IN_mem_write && (bus.IN_funct3 > 3'b010))
            illegal = 1'b1;
    end

    // Narrow stores replicate their data across every lane; byteen selects the live one.
    always_comb begin
        store_en   = 4'b1111;
        store_word = bus.IN_store_data;
        case (bus.IN_funct3[1:0])
            2'b00: begin
                store_en   = 4'b0001 << bus.IN_address[1:0];
                store_word = {4{bus.IN_store_data[7:0]}};
            end
            2'b01: begin
                store_en   = 4'b0011 << bus.IN_address[1:0];
                store_word = {2{bus.IN_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane = bus.mem_readdata >> {offset_q, 3'b000};
        case (funct3_q)
            3'b000:  load_value = {{24{lane[7]}}, lane[7:0]};
            3'b001:  load_value = {{16{lane[15]}}, lane[15:0]};
            3'b100:  load_value = {24'b0, lane[7:0]};
            3'b101:  load_value = {16'b0, lane[15:0]};
            default: load_value = lane;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            wd_count          <= 8'd0;
            funct3_q          <= 3'b000;
            offset_q          <= 2'b00;
            is_load_q         <= 1'b0;
            bus.dmem_out      <= 32'd0;
            bus.access_fault  <= 1'b0;
            bus.mem_read      <= 1'b0;
            bus.mem_write     <= 1'b0;
            bus.mem_address   <= 32'd0;
            bus.mem_writedata <= 32'd0;
            bus.mem_byteen    <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (request) begin
                        if (illegal) begin
                            state            <= DONE;
                            bus.access_fault <= 1'b1;
                        end else begin
                            state             <= ACCESS;
                            wd_count          <= 8'd0;
                            funct3_q          <= bus.IN_funct3;
                            offset_q          <= bus.IN_address[1:0];
                            is_load_q         <= bus.IN_mem_read;
                            bus.mem_read      <= bus.IN_mem_read;
                            bus.mem_write     <= bus.IN_mem_write;
                            bus.mem_address   <= {bus.IN_address[31:2], 2'b00};
                            bus.mem_writedata <= store_word;
                            bus.mem_byteen    <= bus.IN_mem_write ? store_en : 4'b0000;
                        end
                    end
                end
                ACCESS: begin
                    if (!bus.mem_busywait) begin
                        state         <= DONE;
                        bus.mem_read  <= 1'b0;
                        bus.mem_write <= 1'b0;
                        if (is_load_q)
                            bus.dmem_out <= load_value;
                    end else if (wd_count == 8'(TIMEOUT_CYCLES - 1)) begin
                        // Watchdog expiry: abandon the access and report it as a fault.
                        state            <= DONE;
                        bus.mem_read     <= 1'b0;
                        bus.mem_write    <= 1'b0;
                        bus.access_fault <= 1'b1;
                    end else begin
                        wd_count <= wd_count + 8'd1;
                    end
                end
                DONE: begin
                    state            <= IDLE;
                    bus.access_fault <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dmem_access_unit.md
DMEM_ACCESS_UNIT -- requirements
Module: dmem_access_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, max consecutive ACCESS cycles with mem_busywait=1 before abort (range 2..255).
REQ-002 clk  in  1  system clock; all state changes on posedge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 IN_address  in  32  byte address from ALU result.
REQ-005 IN_store_data  in  32  rs2 value for stores.
REQ-006 IN_mem_read  in  1  load request.
REQ-007 IN_mem_write  in  1  store request.
REQ-008 IN_funct3  in  3  access width/sign code.
REQ-009 busywait  out  1  pipeline stall; all pipeline registers hold while high.
REQ-010 dmem_out  out  32  aligned, extended load result to MEM/WB register.
REQ-011 access_fault  out  1  one-cycle fault flag for current access.
REQ-012 mem_read, mem_write  out  1 each  memory strobes.
REQ-013 mem_address  out  32  word-aligned address {addr[31:2],2'b00}.
REQ-014 mem_writedata  out  32  lane-replicated store data.
REQ-015 mem_byteen  out  4  byte-lane write enables.
REQ-016 mem_readdata  in  32  memory read word.
REQ-017 mem_busywait  in  1  memory not ready.

Function
REQ-018 States SHALL be IDLE, ACCESS, DONE; memory strobes SHALL be registered and high only in ACCESS.
REQ-019 Request = IN_mem_read | IN_mem_write, sampled only in IDLE; inputs in ACCESS/DONE SHALL be ignored.
REQ-020 busywait SHALL equal (IDLE & request) | ACCESS, combinationally; low in DONE and in IDLE without request.
REQ-021 Legal request in IDLE: latch address, funct3, store data, direction; next state ACCESS.
REQ-022 Illegal request in IDLE (both read and write; funct3 011/110/111; store funct3 >010; LW/SW addr[1:0]!=0; LH/LHU/SH addr[0]!=0): no memory strobe; next state DONE with access_fault=1.
REQ-023 ACCESS with mem_busywait=0: next DONE; for loads dmem_out loads formatted data at that edge.
REQ-024 Load formatting: lane = mem_readdata >> 8*addr[1:0]; 000 sign-extend byte, 001 sign-extend half, 010 word, 100 zero-extend byte, 101 zero-extend half.
REQ-025 Stores: SB byteen=0001<<addr[1:0], data byte replicated x4; SH byteen=0011<<addr[1:0], half replicated x2; SW byteen=1111, data unchanged; loads byteen=0000.
REQ-026 Watchdog counter SHALL clear on entering ACCESS and increment each ACCESS cycle with mem_busywait=1; on TIMEOUT_CYCLES-th such cycle: drop strobes, next DONE, access_fault=1, dmem_out unchanged.
REQ-027 DONE SHALL last exactly one cycle, then IDLE; access_fault SHALL be high only in DONE.
REQ-028 dmem_out SHALL hold its value except at REQ-023 load completion.
REQ-029 Minimum latency: legal access 3 cycles (IDLE, ACCESS, DONE); illegal access 2 cycles.

Reset
REQ-030 reset high SHALL immediately force IDLE, counter 0, dmem_out=0, access_fault=0, strobes=0, mem_address=0, mem_writedata=0, mem_byteen=0; busywait then follows REQ-020.
REQ-031 Reset during ACCESS SHALL drop strobes at once with no completion or fault; release resumes in IDLE.

Verification
REQ-032 LB addr 0x103, mem_readdata 0x80FF_0000, mem_busywait low in first ACCESS cycle -> mem_address 0x100, busywait high 2 cycles, dmem_out 0xFFFF_FF80 in DONE.
REQ-033 SH addr 0x202, data 0x1234_ABCD -> mem_byteen 1100, mem_writedata 0xABCD_ABCD, mem_write high during ACCESS only.
REQ-034 LW addr 0x006 -> no strobe, busywait high 1 cycle, access_fault=1 next cycle, dmem_out unchanged.
REQ-035 LHU addr 0x40, mem_busywait high 5 cycles then low, readdata 0x0000_9ABC -> busywait high 7 cycles, dmem_out 0x0000_9ABC.
REQ-036 mem_busywait stuck high, TIMEOUT_CYCLES=64 -> exactly 64 ACCESS cycles, then DONE with access_fault=1, strobes low.
REQ-037 Assert reset mid-ACCESS of SW -> mem_write low same time, all outputs zero; after release a new LW completes normally.
